// File: rtl/conv_mac_alu_if.sv
// Window/kernel request and packed-pixel response bundle for conv_mac_alu.
// The master side is the fetch/consumer logic, the slave side is the ALU.
interface conv_mac_alu_if #(
  parameter int unsigned CH   = 3,
  parameter int unsigned CW   = 4,
  parameter int unsigned TAPS = 9,
  parameter int unsigned KW   = 5,
  parameter int unsigned SHW  = 3,
  parameter int unsigned AW   = 17
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [TAPS*CH*CW-1:0]    din;
  logic [TAPS*KW-1:0]       kernel;
  logic [SHW-1:0]           shift;
  logic [1:0]               mode;
  logic [AW-1:0]            raddr;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH*CW-1:0]         dout;
  logic [AW-1:0]            waddr;

  modport master (
    output in_valid, din, kernel, shift, mode, raddr, out_ready,
    input  in_ready, out_valid, dout, waddr
  );

  modport slave (
    input  in_valid, din, kernel, shift, mode, raddr, out_ready,
    output in_ready, out_valid, dout, waddr
  );
endinterface

// File: rtl/conv_mac_alu.sv
// Time-multiplexed convolution MAC: one tap per cycle, one multiplier per channel,
// followed by shift/mode post-processing and saturation to CW bits.
module conv_mac_alu #(
  parameter int unsigned CH   = 3,
  parameter int unsigned CW   = 4,
  parameter int unsigned TAPS = 9,
  parameter int unsigned KW   = 5,
  parameter int unsigned SHW  = 3,
  parameter int unsigned AW   = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_mac_alu_if.slave bus
);
  localparam int unsigned ACCW = CW + 1 + KW + $clog2(TAPS);
  localparam int unsigned TW   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned DW   = TAPS * CH * CW;
  localparam logic [TW-1:0]        LastTap = TW'(TAPS - 1);
  localparam logic signed [ACCW:0] Offs    = (ACCW + 1)'(2 ** (CW - 1));
  localparam logic signed [ACCW:0] MaxV    = (ACCW + 1)'(2 ** CW - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StPost, StOut} state_e;

  state_e                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [DW-1:0]          din_q, din_d;
  logic [TAPS*KW-1:0]     kern_q, kern_d;
  logic [SHW-1:0]         shift_q, shift_d;
  logic [1:0]             mode_q, mode_d;
  logic [AW-1:0]          raddr_q, raddr_d;
  logic [AW-1:0]          waddr_q, waddr_d;
  logic [CH*CW-1:0]       dout_q, dout_d;
  logic [TW-1:0]          tap_q, tap_d;
  logic signed [ACCW-1:0] acc_q [CH];
  logic signed [ACCW-1:0] acc_d [CH];
  logic signed [ACCW-1:0] prod  [CH];
  logic [CW-1:0]          res   [CH];
  logic signed [KW-1:0]   coef;

  assign coef = kern_q[tap_q*KW +: KW];

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [CW-1:0]        pix, mid;
    logic signed [ACCW:0] acc_x, mag, r;

    assign pix     = din_q[(tap_q*CH + c)*CW +: CW];
    assign mid     = din_q[((TAPS/2)*CH + c)*CW +: CW];
    assign prod[c] = $signed({{(ACCW-CW){1'b0}}, pix}) *
                     $signed({{(ACCW-KW){coef[KW-1]}}, coef});
    // One extra bit so |most negative acc| is representable.
    assign acc_x   = {acc_q[c][ACCW-1], acc_q[c]};
    assign mag     = acc_x[ACCW] ? -acc_x : acc_x;

    always_comb begin
      r = '0;
      case (mode_q)
        2'd0: r = mag >> shift_q;
        2'd1: r = acc_x[ACCW] ? '0 : (acc_x >> shift_q);
        2'd2: begin
          r = (acc_x >>> shift_q) + Offs;
          if (r[ACCW]) r = '0;
        end
        default: r = {{(ACCW+1-CW){1'b0}}, mid};
      endcase
    end

    assign res[c] = (r > MaxV) ? MaxV[CW-1:0] : r[CW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    din_d       = din_q;
    kern_d      = kern_q;
    shift_d     = shift_q;
    mode_d      = mode_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    dout_d      = dout_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          din_d      = bus.din;
          kern_d     = bus.kernel;
          shift_d    = bus.shift;
          mode_d     = bus.mode;
          raddr_d    = bus.raddr;
          tap_d      = '0;
          for (int c = 0; c < CH; c++) acc_d[c] = '0;
          in_ready_d = 1'b0;
          state_d    = StAcc;
        end
      end
      StAcc: begin
        for (int c = 0; c < CH; c++) acc_d[c] = acc_q[c] + prod[c];
        tap_d = tap_q + 1'b1;
        if (tap_q == LastTap) begin
          tap_d   = '0;
          state_d = StPost;
        end
      end
      StPost: begin
        for (int c = 0; c < CH; c++) dout_d[c*CW +: CW] = res[c];
        waddr_d     = raddr_q;
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      din_q       <= '0;
      kern_q      <= '0;
      shift_q     <= '0;
      mode_q      <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      dout_q      <= '0;
      tap_q       <= '0;
      acc_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      din_q       <= din_d;
      kern_q      <= kern_d;
      shift_q     <= shift_d;
      mode_q      <= mode_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      dout_q      <= dout_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.waddr     = waddr_q;
endmodule

// File: tb/tb_conv_mac_alu.sv
// Scoreboard bench for conv_mac_alu: directed cases plus randomized traffic
// checked against an integer reference model of the convolution rules.
module tb_conv_mac_alu;
  localparam int unsigned CH   = 3;
  localparam int unsigned CW   = 4;
  localparam int unsigned TAPS = 9;
  localparam int unsigned KW   = 5;
  localparam int unsigned SHW  = 3;
  localparam int unsigned AW   = 17;
  localparam int unsigned DW   = TAPS * CH * CW;
  localparam int unsigned PW   = CH * CW;
  localparam int unsigned KTW  = TAPS * KW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_mac_alu_if #(.CH(CH), .CW(CW), .TAPS(TAPS), .KW(KW), .SHW(SHW), .AW(AW)) bus ();

  conv_mac_alu #(.CH(CH), .CW(CW), .TAPS(TAPS), .KW(KW), .SHW(SHW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [PW-1:0] dv;
    logic [AW-1:0] av;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  exp_t e_cur;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // Integer reference: plain sum of products, then the mode rules and saturation.
  function automatic logic [PW-1:0] model(input logic [DW-1:0] d, input logic [KTW-1:0] k,
                                          input int s, input int m);
    logic [PW-1:0]        res;
    logic [CW-1:0]        pv;
    logic signed [KW-1:0] kv;
    int                   acc, r;
    res = '0;
    for (int c = 0; c < CH; c++) begin
      acc = 0;
      for (int t = 0; t < TAPS; t++) begin
        pv  = d[(t*CH + c)*CW +: CW];
        kv  = k[t*KW +: KW];
        acc += int'(pv) * int'(kv);
      end
      case (m)
        0: r = ((acc < 0) ? -acc : acc) >> s;
        1: r = (acc < 0) ? 0 : (acc >> s);
        2: begin
          r = (acc >>> s) + 2 ** (CW - 1);
          if (r < 0) r = 0;
        end
        default: begin
          pv = d[((TAPS/2)*CH + c)*CW +: CW];
          r  = int'(pv);
        end
      endcase
      if (r > 2 ** CW - 1) r = 2 ** CW - 1;
      res[c*CW +: CW] = r[CW-1:0];
    end
    return res;
  endfunction

  function automatic logic [DW-1:0] mk_din(input logic [PW-1:0] ctr, input logic [PW-1:0] oth,
                                           input int ci);
    logic [DW-1:0] d;
    for (int t = 0; t < TAPS; t++) d[t*PW +: PW] = (t == ci) ? ctr : oth;
    return d;
  endfunction

  function automatic logic [KTW-1:0] mk_k(input logic [KW-1:0] ctr, input logic [KW-1:0] oth,
                                          input int ci);
    logic [KTW-1:0] k;
    for (int t = 0; t < TAPS; t++) k[t*KW +: KW] = (t == ci) ? ctr : oth;
    return k;
  endfunction

  function automatic logic [DW-1:0] rand_din();
    logic [DW-1:0] d;
    for (int i = 0; i < TAPS * CH; i++) d[i*CW +: CW] = CW'($urandom);
    return d;
  endfunction

  function automatic logic [KTW-1:0] rand_k();
    logic [KTW-1:0] k;
    for (int t = 0; t < TAPS; t++) k[t*KW +: KW] = KW'($urandom);
    return k;
  endfunction

  // Monitor: latency on each out_valid rise, result on each output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (bus.out_valid && !ov_prev) begin
        if (lat_q.size() == 0) fail("out_valid_without_transaction");
        else chk("latency", cyc - lat_q.pop_front(), TAPS + 1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail("result_without_transaction");
        end else begin
          e_cur = exp_q.pop_front();
          chk("dout", 32'(bus.dout), 32'(e_cur.dv));
          chk("waddr", 32'(bus.waddr), 32'(e_cur.av));
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  task automatic issue(input logic [DW-1:0] d, input logic [KTW-1:0] k, input logic [SHW-1:0] s,
                       input logic [1:0] m, input logic [AW-1:0] a, input logic [PW-1:0] want);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    bus.din      = d;
    bus.kernel   = k;
    bus.shift    = s;
    bus.mode     = m;
    bus.raddr    = a;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      fail("accept_timeout");
      bus.in_valid = 1'b0;
      return;
    end
    lat_q.push_back(cyc + 1);
    exp_q.push_back('{dv: want, av: a});
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the latched copy must be used.
    bus.in_valid = 1'b0;
    bus.din      = rand_din();
    bus.kernel   = rand_k();
    bus.shift    = SHW'($urandom);
    bus.mode     = 2'($urandom);
    bus.raddr    = AW'($urandom);
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
  endtask

  logic [DW-1:0]  d_id, d_ff, d_off, d_r;
  logic [KTW-1:0] k_id, k_m1, k_off, k_r;
  logic [PW-1:0]  hd;
  logic [AW-1:0]  ha;
  logic [SHW-1:0] s_r;
  logic [1:0]     m_r;
  logic [AW-1:0]  a_r;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.kernel    = '0;
    bus.shift     = '0;
    bus.mode      = '0;
    bus.raddr     = '0;
    bus.out_ready = 1'b1;
    d_id  = mk_din(12'h5A3, 12'hFFF, TAPS / 2);
    k_id  = mk_k(5'd1, 5'd0, TAPS / 2);
    d_ff  = mk_din(12'hFFF, 12'hFFF, 0);
    k_m1  = mk_k(5'h1F, 5'h1F, 0);
    d_off = mk_din(12'h666, 12'h000, 0);
    k_off = mk_k(5'h1F, 5'h00, 0);

    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 0);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_dout", 32'(bus.dout), 0);
    chk("reset_waddr", 32'(bus.waddr), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", 32'(bus.in_ready), 1);

    issue(d_id, k_id, 3'd0, 2'd0, 17'h1234, 12'h5A3);
    drain(1'b0);
    issue(d_ff, k_m1, 3'd0, 2'd0, 17'h00001, 12'hFFF);
    drain(1'b0);
    issue(d_ff, k_m1, 3'd4, 2'd0, 17'h00002, 12'h888);
    drain(1'b0);
    issue(d_ff, k_m1, 3'd0, 2'd1, 17'h00003, 12'h000);
    drain(1'b0);
    issue(d_off, k_off, 3'd1, 2'd2, 17'h00004, 12'h555);
    drain(1'b0);
    // Most negative coefficient everywhere: acc = -2160 per channel.
    issue(d_ff, mk_k(5'h10, 5'h10, 0), 3'd7, 2'd0, 17'h00005, 12'hFFF);
    drain(1'b0);
    issue(d_ff, mk_k(5'h10, 5'h10, 0), 3'd3, 2'd2, 17'h00006, 12'h000);
    drain(1'b0);
    d_r = rand_din();
    d_r[(TAPS/2)*PW +: PW] = 12'h123;
    issue(d_r, rand_k(), 3'd7, 2'd3, 17'h00007, 12'h123);
    drain(1'b0);

    // Backpressure with a competing request held valid.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue(d_id, k_id, 3'd0, 2'd0, 17'h0AAAA, 12'h5A3);
    bus.din      = d_off;
    bus.kernel   = k_off;
    bus.shift    = 3'd1;
    bus.mode     = 2'd2;
    bus.raddr    = 17'h1FFFF;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) fail("bp_out_valid_timeout");
    hd = bus.dout;
    ha = bus.waddr;
    repeat (5) begin
      @(negedge clk);
      chk("bp_dout_hold", 32'(bus.dout), 32'(hd));
      chk("bp_waddr_hold", 32'(bus.waddr), 32'(ha));
      chk("bp_out_valid_hold", 32'(bus.out_valid), 1);
      chk("bp_in_ready_low", 32'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after_handshake", 32'(bus.in_ready), 1);
    chk("bp_out_valid_cleared", 32'(bus.out_valid), 0);
    issue(d_off, k_off, 3'd1, 2'd2, 17'h1FFFF, 12'h555);
    drain(1'b0);

    // Reset during the fourth accumulate cycle.
    issue(d_ff, k_m1, 3'd4, 2'd0, 17'h0BEEF, 12'h888);
    drain(1'b0);
    issue(d_id, k_id, 3'd0, 2'd0, 17'h01111, 12'h5A3);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(bus.out_valid), 0);
    chk("midreset_dout", 32'(bus.dout), 0);
    chk("midreset_in_ready", 32'(bus.in_ready), 0);
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(d_id, k_id, 3'd0, 2'd0, 17'h1234, 12'h5A3);
    drain(1'b0);

    for (int i = 0; i < 30; i++) begin
      d_r = rand_din();
      k_r = ($urandom_range(0, 4) == 0) ? mk_k(5'h10, 5'h10, 0) : rand_k();
      s_r = SHW'($urandom);
      m_r = 2'($urandom);
      a_r = AW'($urandom);
      issue(d_r, k_r, s_r, m_r, a_r, model(d_r, k_r, int'(s_r), int'(m_r)));
      drain(1'b1);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
